s3g_tx_pkt: RTL and testbench

//  Parametrised S3G packet framer, successor to the fixed 16-byte transmitter.

---
 rtl/s3g_pkg.sv | 25 ++
 rtl/s3g_pkt_slot.sv | 50 +++++
 rtl/s3g_tx_pkt.sv | 180 ++++++++++++++++++
 tb/tb_s3g_tx_pkt.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/s3g_pkg.sv
// Shared S3G framing definitions: start byte, framer states and the CRC-8/MAXIM step.
// Used by both the transmit framer and the receiver.
package s3g_pkg;

    localparam logic [7:0] S3G_START = 8'hD5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_LEN,
        ST_DATA,
        ST_CRC
    } s3g_state_e;

    // One byte of reflected CRC-8/MAXIM (poly 0x8C, LSB first).
    function automatic logic [7:0] crc8_maxim(input logic [7:0] crc, input logic [7:0] data_byte);
        logic [7:0] c;
        c = crc ^ data_byte;
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/s3g_pkt_slot.sv
// One packet holding register (length + flat payload) with a valid flag.
// Load wins over clear.
module s3g_pkt_slot #(
    parameter int MAX_PAYLOAD = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     clear,
    input  logic [7:0]               len_in,
    input  logic [8*MAX_PAYLOAD-1:0] data_in,
    output logic                     valid,
    output logic [7:0]               len,
    output logic [8*MAX_PAYLOAD-1:0] data
);

    logic                     valid_q, valid_d;
    logic [7:0]               len_q, len_d;
    logic [8*MAX_PAYLOAD-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        len_d   = len_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            len_d   = len_in;
            data_d  = data_in;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            len_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            len_q   <= len_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign len   = len_q;
    assign data  = data_q;

endmodule

// File: rtl/s3g_tx_pkt.sv
// S3G packet framer: START, LEN, payload, CRC8 written byte-by-byte to a UART TX,
// with an active slot being sent and a pending slot for the next packet.
module s3g_tx_pkt
    import s3g_pkg::*;
#(
    parameter int         MAX_PAYLOAD = 16,
    parameter logic [7:0] START_BYTE  = S3G_START,
    parameter bit         LEN_CHECK   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     packet_wr,
    input  logic [7:0]               payload_len,
    input  logic [8*MAX_PAYLOAD-1:0] payload,
    output logic                     ready,
    output logic                     busy,
    output logic [7:0]               tx_data,
    output logic                     tx_wr,
    input  logic                     tx_done,
    output logic                     pkt_sent,
    output logic                     len_err,
    output logic                     ovf_err
);

    localparam int         IW      = $clog2(MAX_PAYLOAD + 1);
    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

    s3g_state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    crc_q, crc_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_wr_q, tx_wr_d;
    logic          pkt_sent_q, pkt_sent_d;
    logic          len_err_q, len_err_d;
    logic          ovf_err_q, ovf_err_d;

    logic                     act_valid, pend_valid;
    logic [7:0]               act_len, pend_len, act_len_in, in_len, cur_byte;
    logic [8*MAX_PAYLOAD-1:0] act_data, pend_data, act_data_in;
    logic                     len_bad, accept, cap_act, cap_pend;
    logic                     promote, act_load, act_clear;

    always_comb begin
        len_bad  = LEN_CHECK && (payload_len > MAX_LEN);
        in_len   = (payload_len > MAX_LEN) ? MAX_LEN : payload_len;
        accept   = packet_wr && !pend_valid && !len_bad;
        cap_act  = accept && (state_q == ST_IDLE) && !act_valid;
        cap_pend = accept && !cap_act;
    end

    always_comb begin
        cur_byte = '0;
        for (int i = 0; i < MAX_PAYLOAD; i++) begin
            if (idx_q == IW'(i)) cur_byte = act_data[8*i +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        crc_d      = crc_q;
        tx_data_d  = tx_data_q;
        tx_wr_d    = 1'b0;
        pkt_sent_d = 1'b0;
        len_err_d  = packet_wr && !pend_valid && len_bad;
        ovf_err_d  = packet_wr && pend_valid;
        promote    = 1'b0;
        act_clear  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A pending packet can be stranded here if it was captured
                // while the previous frame was closing; pick it up directly.
                if (cap_act || pend_valid) begin
                    promote   = !cap_act;
                    tx_data_d = START_BYTE;
                    tx_wr_d   = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (tx_done) begin
                    tx_data_d = act_len;
                    tx_wr_d   = 1'b1;
                    idx_d     = '0;
                    crc_d     = '0;
                    state_d   = ST_LEN;
                end
            end
            ST_LEN, ST_DATA: begin
                if (tx_done) begin
                    tx_wr_d = 1'b1;
                    if (8'(idx_q) < act_len) begin
                        tx_data_d = cur_byte;
                        crc_d     = crc8_maxim(crc_q, cur_byte);
                        idx_d     = idx_q + IW'(1);
                        state_d   = ST_DATA;
                    end else begin
                        tx_data_d = crc_q;
                        state_d   = ST_CRC;
                    end
                end
            end
            ST_CRC: begin
                if (tx_done) begin
                    pkt_sent_d = 1'b1;
                    if (pend_valid) begin
                        promote   = 1'b1;
                        tx_data_d = START_BYTE;
                        tx_wr_d   = 1'b1;
                        state_d   = ST_START;
                    end else begin
                        act_clear = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            crc_q      <= '0;
            tx_data_q  <= '0;
            tx_wr_q    <= 1'b0;
            pkt_sent_q <= 1'b0;
            len_err_q  <= 1'b0;
            ovf_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            crc_q      <= crc_d;
            tx_data_q  <= tx_data_d;
            tx_wr_q    <= tx_wr_d;
            pkt_sent_q <= pkt_sent_d;
            len_err_q  <= len_err_d;
            ovf_err_q  <= ovf_err_d;
        end
    end

    assign act_load    = cap_act || promote;
    assign act_len_in  = promote ? pend_len : in_len;
    assign act_data_in = promote ? pend_data : payload;

    s3g_pkt_slot #(.MAX_PAYLOAD(MAX_PAYLOAD)) u_active (
        .clk     (clk),
        .rst     (rst),
        .load    (act_load),
        .clear   (act_clear),
        .len_in  (act_len_in),
        .data_in (act_data_in),
        .valid   (act_valid),
        .len     (act_len),
        .data    (act_data)
    );

    s3g_pkt_slot #(.MAX_PAYLOAD(MAX_PAYLOAD)) u_pending (
        .clk     (clk),
        .rst     (rst),
        .load    (cap_pend),
        .clear   (promote),
        .len_in  (in_len),
        .data_in (payload),
        .valid   (pend_valid),
        .len     (pend_len),
        .data    (pend_data)
    );

    assign ready    = !pend_valid;
    // pkt_sent_q keeps busy up through the pkt_sent cycle of the last packet.
    assign busy     = act_valid || pend_valid || pkt_sent_q;
    assign tx_data  = tx_data_q;
    assign tx_wr    = tx_wr_q;
    assign pkt_sent = pkt_sent_q;
    assign len_err  = len_err_q;
    assign ovf_err  = ovf_err_q;

endmodule

// File: tb/tb_s3g_tx_pkt.sv
// Directed bench for s3g_tx_pkt: dut0 (LEN_CHECK=1) with an auto tx_done responder and
// byte scoreboard, dut1 (LEN_CHECK=0) stepped by hand for the clamp case.
module tb_s3g_tx_pkt;

    localparam int MP = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, wr0, wr1, done0, done1;
    logic [7:0] len0, len1;
    logic [8*MP-1:0] pay0, pay1;
    logic ready0, busy0, txw0, sent0, lerr0, oerr0;
    logic ready1, busy1, txw1, sent1, lerr1, oerr1;
    logic [7:0] txd0, txd1;

    s3g_tx_pkt #(.MAX_PAYLOAD(MP), .START_BYTE(8'hD5), .LEN_CHECK(1'b1)) dut0 (
        .clk(clk), .rst(rst0), .packet_wr(wr0), .payload_len(len0), .payload(pay0),
        .ready(ready0), .busy(busy0), .tx_data(txd0), .tx_wr(txw0), .tx_done(done0),
        .pkt_sent(sent0), .len_err(lerr0), .ovf_err(oerr0));

    s3g_tx_pkt #(.MAX_PAYLOAD(MP), .START_BYTE(8'hD5), .LEN_CHECK(1'b0)) dut1 (
        .clk(clk), .rst(rst1), .packet_wr(wr1), .payload_len(len1), .payload(pay1),
        .ready(ready1), .busy(busy1), .tx_data(txd1), .tx_wr(txw1), .tx_done(done1),
        .pkt_sent(sent1), .len_err(lerr1), .ovf_err(oerr1));

    int compared = 0, mismatched = 0;
    logic [7:0] sb0[$], sb1[$];
    int  dly0 = 1, pend0 = 0;
    bit  resp_en0 = 1'b0, prev_wr0 = 1'b0;
    int  wr_cnt0 = 0, sent_cnt0 = 0, b2b_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mcrc(input int n, input logic [8*MP-1:0] p);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            c = c ^ p[8*i +: 8];
            for (int k = 0; k < 8; k++) c = c[0] ? ({1'b0, c[7:1]} ^ 8'h8C) : {1'b0, c[7:1]};
        end
        return c;
    endfunction

    task automatic push_frame(input bit sel, input logic [7:0] lbyte, input logic [8*MP-1:0] p,
                              input logic [7:0] c);
        logic [7:0] q[$];
        q.push_back(8'hD5);
        q.push_back(lbyte);
        for (int i = 0; i < int'(lbyte); i++) q.push_back(p[8*i +: 8]);
        q.push_back(c);
        foreach (q[i]) begin
            if (sel) sb1.push_back(q[i]);
            else     sb0.push_back(q[i]);
        end
    endtask

    task automatic wr_pkt(input bit sel, input logic [7:0] l, input logic [8*MP-1:0] p);
        @(posedge clk); #1;
        if (sel) begin wr1 = 1'b1; len1 = l; pay1 = p; end
        else     begin wr0 = 1'b1; len0 = l; pay0 = p; end
        @(posedge clk); #1;
        wr0 = 1'b0;
        wr1 = 1'b0;
    endtask

    task automatic wait_done0(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (sb0.size() == 0 && !busy0) break;
        end
        chk({tag, "_drained"}, sb0.size(), 0);
        chk({tag, "_busy_end"}, busy0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_data"}, txd0, 0);
        chk({tag, "_tx_wr"}, txw0, 0);
        chk({tag, "_busy"}, busy0, 0);
        chk({tag, "_ready"}, ready0, 1);
        chk({tag, "_pkt_sent"}, sent0, 0);
        chk({tag, "_len_err"}, lerr0, 0);
        chk({tag, "_ovf_err"}, oerr0, 0);
    endtask

    // UART model for dut0: tx_done arrives dly0 cycles after each tx_wr.
    always @(negedge clk) begin
        if (resp_en0) begin
            done0 = 1'b0;
            if (pend0 > 0) begin
                pend0--;
                if (pend0 == 0) done0 = 1'b1;
            end
            if (txw0) pend0 = dly0;
        end else begin
            pend0 = 0;
        end
    end

    // Scoreboard monitor for dut0.
    always @(negedge clk) begin
        if (txw0) begin
            wr_cnt0++;
            chk("wr_gap", prev_wr0, 0);
            compared++;
            assert (sb0.size() != 0) else begin
                mismatched++;
                $error("FAIL unexp_wr: tx_wr with data %0h, none expected", txd0);
            end
            if (sb0.size() != 0) chk("tx_byte", txd0, sb0.pop_front());
            if (txd0 == 8'hD5 && sent0) b2b_cnt++;
        end
        if (sent0) sent_cnt0++;
        prev_wr0 = txw0;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8*MP-1:0] p;
        int base, found;
        rst0 = 1'b1; rst1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0; done0 = 1'b0; done1 = 1'b0;
        len0 = '0; len1 = '0; pay0 = '0; pay1 = '0;
        repeat (2) @(posedge clk); #1;
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst");
        resp_en0 = 1'b1;

        // 1: len=1, byte 0x01 -> D5 01 01 5E
        dly0 = 1; sent_cnt0 = 0;
        push_frame(0, 8'd1, 128'h01, 8'h5E);
        wr_pkt(0, 8'd1, 128'h01);
        @(negedge clk);
        chk("t1_lat_wr", txw0, 1);
        chk("t1_lat_data", txd0, 8'hD5);
        chk("t1_busy", busy0, 1);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (sent0) begin found = 1; break; end
        end
        chk("t1_sent_seen", found, 1);
        chk("t1_busy_at_sent", busy0, 1);
        @(negedge clk);
        chk("t1_busy_after", busy0, 0);
        chk("t1_sent_once", sent_cnt0, 1);
        chk("t1_drained", sb0.size(), 0);

        // 2: empty payload
        push_frame(0, 8'd0, '0, 8'h00);
        wr_pkt(0, 8'd0, '0);
        wait_done0("t2", 100);

        // 3: "123456789" with fast and slow UART
        p = '0;
        p[71:0] = 72'h393837363534333231;
        dly0 = 1;
        push_frame(0, 8'd9, p, 8'hA1);
        wr_pkt(0, 8'd9, p);
        wait_done0("t3a", 200);
        dly0 = 20; base = wr_cnt0;
        push_frame(0, 8'd9, p, 8'hA1);
        wr_pkt(0, 8'd9, p);
        wait_done0("t3b", 600);
        chk("t3b_wr_count", wr_cnt0 - base, 12);

        // 4: queued packet, back-to-back, overflow
        dly0 = 2; sent_cnt0 = 0; b2b_cnt = 0;
        push_frame(0, 8'd2, 128'hBBAA, mcrc(2, 128'hBBAA));
        push_frame(0, 8'd1, 128'hCC, mcrc(1, 128'hCC));
        wr_pkt(0, 8'd2, 128'hBBAA);
        @(posedge clk);
        wr_pkt(0, 8'd1, 128'hCC);
        @(negedge clk);
        chk("t4_ready_low", ready0, 0);
        wr_pkt(0, 8'd1, 128'h77);
        @(negedge clk);
        chk("t4_ovf", oerr0, 1);
        wait_done0("t4", 300);
        chk("t4_sent_cnt", sent_cnt0, 2);
        chk("t4_back2back", b2b_cnt, 1);
        chk("t4_ready_back", ready0, 1);

        // 5: over-length packet rejected on dut0
        base = wr_cnt0;
        wr_pkt(0, 8'd17, {MP{8'h5A}});
        @(negedge clk);
        chk("t5_len_err", lerr0, 1);
        chk("t5_busy", busy0, 0);
        repeat (10) @(negedge clk);
        chk("t5_no_wr", wr_cnt0 - base, 0);
        chk("t5_busy_later", busy0, 0);

        // 5b: dut1 clamps len 17 to 16
        for (int i = 0; i < MP; i++) p[8*i +: 8] = 8'(i * 7 + 3);
        push_frame(1, 8'h10, p, mcrc(MP, p));
        wr_pkt(1, 8'd17, p);
        @(negedge clk);
        while (sb1.size() != 0) begin
            found = 0;
            for (int t = 0; t < 50; t++) begin
                if (txw1) begin found = 1; break; end
                @(negedge clk);
            end
            chk("t5b_wr_seen", found, 1);
            chk("t5b_byte", txd1, sb1.pop_front());
            @(negedge clk); done1 = 1'b1;
            @(negedge clk); done1 = 1'b0;
            if (found == 0) sb1.delete();
        end
        chk("t5b_sent", sent1, 1);

        // 6: reset mid-frame, stray tx_done, then a clean frame
        dly0 = 1;
        for (int i = 0; i < 8; i++) p[8*i +: 8] = 8'(8'h40 + i);
        push_frame(0, 8'd8, p, mcrc(8, p));
        base = wr_cnt0;
        wr_pkt(0, 8'd8, p);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (wr_cnt0 - base >= 6) begin found = 1; break; end
        end
        chk("t6_reached_byte3", found, 1);
        resp_en0 = 1'b0; done0 = 1'b0;
        sb0.delete();
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        @(negedge clk);
        check_reset_outputs("t6_rst");
        base = wr_cnt0;
        done0 = 1'b1;
        @(negedge clk); done0 = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_stray_no_wr", wr_cnt0 - base, 0);
        chk("t6_stray_busy", busy0, 0);
        resp_en0 = 1'b1;
        push_frame(0, 8'd2, 128'h3412, mcrc(2, 128'h3412));
        wr_pkt(0, 8'd2, 128'h3412);
        @(negedge clk);
        chk("t6_new_lat", txw0, 1);
        wait_done0("t6", 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
